// File: rtl/piano_pkg.sv
// piano_pkg: shared note-map constants and allocator state encoding.
package piano_pkg;
  localparam int NOTE_W = 5;
  localparam int NUM_NOTES = 24;
  localparam logic [NOTE_W-1:0] NOTE_NONE = 5'd31;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} alloc_state_t;
  // Index in this table is the note number; two rows of keys form a piano layout.
  localparam logic [7:0] KEY_MAP [NUM_NOTES] = '{
    8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2D, 8'h2C, 8'h34,
    8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42, 8'h44, 8'h4B, 8'h4D,
    8'h4C, 8'h54, 8'h52, 8'h5B, 8'h15, 8'h1E, 8'h26, 8'h25
  };
endpackage

// File: rtl/key_to_note.sv
// key_to_note: combinational scan-code to note-index lookup; extended codes never map.
import piano_pkg::*;
module key_to_note (
  input  logic [15:0]       evt_code,
  output logic [NOTE_W-1:0] note,
  output logic              hit
);
  always_comb begin
    note = NOTE_NONE;
    hit  = 1'b0;
    for (int i = 0; i < NUM_NOTES; i++)
      if (evt_code[15:8] == 8'h00 && evt_code[7:0] == KEY_MAP[i]) begin
        note = NOTE_W'(i);
        hit  = 1'b1;
      end
  end
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: shares NUM_VOICES tone voices among held keys, stealing the oldest voice when full.
import piano_pkg::*;
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         evt_valid,
  input  logic                         evt_press,
  input  logic [15:0]                  evt_code,
  output logic                         evt_ready,
  output logic [NUM_VOICES-1:0]        voice_on,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic                         steal,
  output logic                         unmapped
);
  localparam int IW = $clog2(NUM_VOICES) + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);
  alloc_state_t r_state;
  logic [NUM_VOICES-1:0] r_on;
  logic [NOTE_W-1:0] r_note [NUM_VOICES];
  logic [AGE_W-1:0] r_age [NUM_VOICES];
  logic [IW-1:0] r_idx;
  logic [IW-2:0] r_match_i, r_free_i, r_old_i;
  logic r_match_f, r_free_f, r_old_f;
  logic [AGE_W-1:0] r_old_age;
  logic [NOTE_W-1:0] r_lnote;
  logic r_press, r_unm_p, r_steal, r_unmapped;
  logic [NOTE_W-1:0] w_note;
  logic w_hit, w_acc;
  logic [IW-2:0] w_i, w_tgt;
  key_to_note u_map (.evt_code(evt_code), .note(w_note), .hit(w_hit));
  assign evt_ready = (r_state == IDLE);
  assign w_acc     = evt_valid && evt_ready;
  assign w_i       = r_idx[IW-2:0];
  assign w_tgt     = r_match_f ? r_match_i : r_free_f ? r_free_i : r_old_i;
  assign voice_on  = r_on;
  assign steal     = r_steal;
  assign unmapped  = r_unmapped;
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_note
    assign voice_note[v*NOTE_W +: NOTE_W] = r_note[v];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_on       <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_note[v] <= '0;
        r_age[v]  <= '0;
      end
      r_idx      <= '0;
      r_match_i  <= '0;
      r_free_i   <= '0;
      r_old_i    <= '0;
      r_match_f  <= 1'b0;
      r_free_f   <= 1'b0;
      r_old_f    <= 1'b0;
      r_old_age  <= '0;
      r_lnote    <= '0;
      r_press    <= 1'b0;
      r_unm_p    <= 1'b0;
      r_steal    <= 1'b0;
      r_unmapped <= 1'b0;
    end else begin
      r_steal    <= 1'b0;
      r_unm_p    <= w_acc && !w_hit;
      r_unmapped <= r_unm_p;
      case (r_state)
        IDLE: if (w_acc && w_hit) begin
          r_lnote   <= w_note;
          r_press   <= evt_press;
          r_idx     <= '0;
          r_match_f <= 1'b0;
          r_free_f  <= 1'b0;
          r_old_f   <= 1'b0;
          r_old_age <= '0;
          r_state   <= SCAN;
        end
        SCAN: begin
          if (r_on[w_i] && r_note[w_i] == r_lnote && !r_match_f) begin
            r_match_f <= 1'b1;
            r_match_i <= w_i;
          end
          if (!r_on[w_i] && !r_free_f) begin
            r_free_f <= 1'b1;
            r_free_i <= w_i;
          end
          // Strict greater-than keeps ties on the lower index.
          if (r_on[w_i] && (!r_old_f || r_age[w_i] > r_old_age)) begin
            r_old_f   <= 1'b1;
            r_old_i   <= w_i;
            r_old_age <= r_age[w_i];
          end
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST) r_state <= COMMIT;
        end
        COMMIT: begin
          if (r_press) begin
            for (int v = 0; v < NUM_VOICES; v++)
              if (r_on[v] && r_age[v] != AGE_MAX) r_age[v] <= r_age[v] + 1'b1;
            r_on[w_tgt]   <= 1'b1;
            r_note[w_tgt] <= r_lnote;
            r_age[w_tgt]  <= '0;
            r_steal       <= !r_match_f && !r_free_f;
          end else if (r_match_f) begin
            r_on[r_match_i]  <= 1'b0;
            r_age[r_match_i] <= '0;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed plus random key events checked against a rule-level voice model.
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int AW = 4;
  localparam int AGE_SAT = (1 << AW) - 1;
  logic clk = 1'b0, rst = 1'b0, evt_valid = 1'b0, evt_press = 1'b0;
  logic [15:0] evt_code = '0;
  logic evt_ready, steal, unmapped;
  logic [NV-1:0] voice_on;
  logic [NV*5-1:0] voice_note;
  int n_chk = 0, n_fail = 0;
  logic [7:0] kmap [24] = '{
    8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2D, 8'h2C, 8'h34,
    8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42, 8'h44, 8'h4B, 8'h4D,
    8'h4C, 8'h54, 8'h52, 8'h5B, 8'h15, 8'h1E, 8'h26, 8'h25
  };
  bit m_on [NV];
  int m_note [NV];
  int m_age [NV];
  logic [NV-1:0] exp_on;
  logic [NV*5-1:0] exp_notes;

  voice_allocator #(.NUM_VOICES(NV), .AGE_W(AW)) dut (
    .clk(clk), .rst(rst), .evt_valid(evt_valid), .evt_press(evt_press),
    .evt_code(evt_code), .evt_ready(evt_ready), .voice_on(voice_on),
    .voice_note(voice_note), .steal(steal), .unmapped(unmapped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lookup(input logic [15:0] code);
    if (code[15:8] != 8'h00) return -1;
    for (int i = 0; i < 24; i++) if (kmap[i] == code[7:0]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int v = 0; v < NV; v++) begin
      m_on[v] = 1'b0;
      m_note[v] = 0;
      m_age[v] = 0;
    end
  endtask

  task automatic pack_exp();
    for (int v = 0; v < NV; v++) begin
      exp_on[v] = m_on[v];
      exp_notes[v*5 +: 5] = 5'(m_note[v]);
    end
  endtask

  task automatic model_apply(input bit press, input int note, output bit stl);
    int mi = -1, fi = -1, oi = -1, t;
    for (int v = 0; v < NV; v++) begin
      if (m_on[v] && m_note[v] == note && mi < 0) mi = v;
      if (!m_on[v] && fi < 0) fi = v;
      if (m_on[v] && (oi < 0 || m_age[v] > m_age[oi])) oi = v;
    end
    stl = 1'b0;
    if (press) begin
      t = (mi >= 0) ? mi : (fi >= 0) ? fi : oi;
      stl = (mi < 0 && fi < 0);
      for (int v = 0; v < NV; v++)
        if (m_on[v] && v != t) m_age[v] = (m_age[v] >= AGE_SAT) ? AGE_SAT : m_age[v] + 1;
      m_on[t] = 1'b1;
      m_note[t] = note;
      m_age[t] = 0;
    end else if (mi >= 0) begin
      m_on[mi] = 1'b0;
      m_age[mi] = 0;
    end
  endtask

  // Called at a negedge with the allocator idle; returns at a negedge with it idle again.
  task automatic send(input bit press, input logic [15:0] code);
    int note = lookup(code);
    bit stl;
    pack_exp();
    chk("ready_before", evt_ready, 1'b1);
    evt_valid = 1'b1;
    evt_press = press;
    evt_code = code;
    @(posedge clk);
    @(negedge clk);
    evt_valid = 1'b0;
    if (note < 0) begin
      chk("unm_ready", evt_ready, 1'b1);
      chk("unm_early", unmapped, 1'b0);
      @(negedge clk);
      chk("unm_pulse", unmapped, 1'b1);
      chk("unm_on", voice_on, exp_on);
      chk("unm_notes", voice_note, exp_notes);
      @(negedge clk);
      chk("unm_clear", unmapped, 1'b0);
    end else begin
      for (int k = 0; k <= NV; k++) begin
        chk("busy_ready", evt_ready, 1'b0);
        chk("busy_on", voice_on, exp_on);
        chk("busy_notes", voice_note, exp_notes);
        @(negedge clk);
      end
      model_apply(press, note, stl);
      pack_exp();
      chk("done_ready", evt_ready, 1'b1);
      chk("done_on", voice_on, exp_on);
      chk("done_notes", voice_note, exp_notes);
      chk("done_steal", steal, stl);
      chk("done_unm", unmapped, 1'b0);
      @(negedge clk);
      chk("steal_clear", steal, 1'b0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, evt_ready, 1'b1);
    chk({tag, "_on"}, voice_on, '0);
    chk({tag, "_notes"}, voice_note, '0);
    chk({tag, "_steal"}, steal, 1'b0);
    chk({tag, "_unm"}, unmapped, 1'b0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] code;
    bit pr;
    model_clear();
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b1;
    @(negedge clk);
    send(1'b1, 16'h001C);
    chk("first_on", voice_on, 4'b0001);
    chk("first_note0", voice_note[4:0], 5'd0);
    send(1'b1, 16'h001D);
    send(1'b1, 16'h001B);
    send(1'b1, 16'h0024);
    chk("full_on", voice_on, 4'b1111);
    chk("full_notes", voice_note, {5'd3, 5'd2, 5'd1, 5'd0});
    send(1'b1, 16'h0023);
    chk("steal_v0_note", voice_note, {5'd3, 5'd2, 5'd1, 5'd4});
    pulse_reset();
    send(1'b1, 16'h001D);
    send(1'b1, 16'h001D);
    chk("retrig_on", voice_on, 4'b0001);
    send(1'b0, 16'h001D);
    chk("release_on", voice_on, 4'b0000);
    chk("release_stale", voice_note[4:0], 5'd1);
    send(1'b1, 16'hE075);
    send(1'b1, 16'h0076);
    send(1'b0, 16'h001B);
    send(1'b1, 16'h001C);
    // Reset in the middle of a press scan must drop that press.
    evt_valid = 1'b1;
    evt_press = 1'b1;
    evt_code = 16'h001D;
    @(posedge clk);
    @(negedge clk);
    evt_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_vals("midscan");
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    repeat (NV + 3) @(negedge clk);
    chk("midscan_after_on", voice_on, '0);
    chk("midscan_after_ready", evt_ready, 1'b1);
    for (int n = 0; n < 90; n++) begin
      if ($urandom_range(0, 9) == 0)
        code = $urandom_range(0, 1) ? {8'hE0, 8'($urandom_range(0, 255))} : 16'h0076;
      else
        code = {8'h00, kmap[$urandom_range(0, 6)]};
      pr = ($urandom_range(0, 2) != 0);
      send(pr, code);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
